// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: instruction memory, datapath flags/IR, stall
interface fetch_sequencer_if;
  logic        stall;
  logic [18:0] instruction;
  logic        z_flag;
  logic        c_flag;
  logic [11:0] pc_addr;
  logic [18:0] ir;
  logic        ir_valid;
  logic        stack_err;

  modport master (
    input  stall, instruction, z_flag, c_flag,
    output pc_addr, ir, ir_valid, stack_err
  );

  modport slave (
    output stall, instruction, z_flag, c_flag,
    input  pc_addr, ir, ir_valid, stack_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, return stack and IR for a 12-bit/19-bit fetch path; option macro STACK_GUARD_EN
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC    = 12'd0,
  parameter int          STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  localparam int SP_IDX_W = $clog2(STACK_DEPTH);
`ifdef STACK_GUARD_EN
  // One extra bit so sp can reach STACK_DEPTH and full/empty are distinguishable.
  localparam int SP_W = SP_IDX_W + 1;
`else
  // Bare index: sp wraps and the stack behaves as a circular buffer.
  localparam int SP_W = SP_IDX_W;
`endif

  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JSB = 5'b11101;
  localparam logic [5:0] OP_RET = 6'b111100;
  localparam logic [2:0] OP_BR  = 3'b101;

  logic [11:0]         pc;
  logic [11:0]         pc1;
  logic [11:0]         next_pc;
  logic [11:0]         br_off;
  logic                br_taken;
  logic [18:0]         ir_q;
  logic                ir_valid_q;
  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     sp_next;
  logic                push;
  logic [SP_IDX_W-1:0] wr_idx;
  logic [SP_IDX_W-1:0] rd_idx;
  logic [11:0]         stack [STACK_DEPTH];
`ifdef STACK_GUARD_EN
  logic                err_set;
  logic                stack_err_q;
`endif

  assign wr_idx = sp[SP_IDX_W-1:0];
  assign rd_idx = wr_idx - SP_IDX_W'(1);

  // Decode the word currently on the memory bus into the next PC and stack action.
  always_comb begin
    pc1      = pc + 12'd1;
    next_pc  = pc1;
    push     = 1'b0;
    sp_next  = sp;
    br_taken = 1'b0;
    br_off   = {{4{bus.instruction[7]}}, bus.instruction[7:0]};
`ifdef STACK_GUARD_EN
    err_set  = 1'b0;
`endif
    if (bus.instruction[18:14] == OP_JMP) begin
      next_pc = bus.instruction[11:0];
    end else if (bus.instruction[18:14] == OP_JSB) begin
      next_pc = bus.instruction[11:0];
`ifdef STACK_GUARD_EN
      if (sp == SP_W'(STACK_DEPTH)) begin
        err_set = 1'b1;
      end else begin
        push    = 1'b1;
        sp_next = sp + SP_W'(1);
      end
`else
      push    = 1'b1;
      sp_next = sp + SP_W'(1);
`endif
    end else if (bus.instruction[18:13] == OP_RET) begin
`ifdef STACK_GUARD_EN
      if (sp == '0) begin
        err_set = 1'b1;
      end else begin
        next_pc = stack[rd_idx];
        sp_next = sp - SP_W'(1);
      end
`else
      next_pc = stack[rd_idx];
      sp_next = sp - SP_W'(1);
`endif
    end else if (bus.instruction[18:16] == OP_BR) begin
      case (bus.instruction[15:14])
        2'b00:   br_taken = bus.z_flag;
        2'b01:   br_taken = !bus.z_flag;
        2'b10:   br_taken = bus.c_flag;
        default: br_taken = !bus.c_flag;
      endcase
      if (br_taken) begin
        next_pc = pc1 + br_off;
      end
    end
  end

  // Advance PC, capture IR and update the return stack on every non-stalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      sp         <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (bus.stall) begin
      ir_valid_q <= 1'b0;
    end else begin
      pc         <= next_pc;
      sp         <= sp_next;
      ir_q       <= bus.instruction;
      ir_valid_q <= 1'b1;
      if (push) begin
        stack[wr_idx] <= pc1;
      end
    end
  end

`ifdef STACK_GUARD_EN
  // Sticky overflow/underflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_err_q <= 1'b0;
    end else if (!bus.stall && err_set) begin
      stack_err_q <= 1'b1;
    end
  end

  assign bus.stack_err = stack_err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.pc_addr  = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [18:0] mem [4096];

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(12'd0), .STACK_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.instruction = mem[bus.pc_addr];

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic [18:0] word;
    logic        z;
    logic        c;
    logic [11:0] exp_pc;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [18:0] op_jmp(input logic [11:0] a);
    return {5'b11100, 2'b00, a};
  endfunction

  function automatic logic [18:0] op_jsb(input logic [11:0] a);
    return {5'b11101, 2'b00, a};
  endfunction

  function automatic logic [18:0] op_ret();
    return {6'b111100, 13'd0};
  endfunction

  function automatic logic [18:0] op_br(input logic [1:0] cond, input logic [7:0] off);
    return {3'b101, cond, 6'd0, off};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  logic [11:0] ret_seq [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected test to finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall  = 1'b0;
    bus.z_flag = 1'b0;
    bus.c_flag = 1'b0;
    clear_mem();

    vecs[0]  = '{"jmp15",      12'd10,   19'b1110000000000001111, 1'b0, 1'b0, 12'd15};
    vecs[1]  = '{"brz_taken",  12'd25,   op_br(2'b00, 8'd3),      1'b1, 1'b0, 12'd29};
    vecs[2]  = '{"brz_not",    12'd25,   op_br(2'b00, 8'd3),      1'b0, 1'b0, 12'd26};
    vecs[3]  = '{"brnz_taken", 12'd25,   op_br(2'b01, 8'd3),      1'b0, 1'b0, 12'd29};
    vecs[4]  = '{"brnz_not",   12'd25,   op_br(2'b01, 8'd3),      1'b1, 1'b0, 12'd26};
    vecs[5]  = '{"brc_back",   12'd30,   op_br(2'b10, 8'hFE),     1'b0, 1'b1, 12'd29};
    vecs[6]  = '{"brc_not",    12'd30,   op_br(2'b10, 8'hFE),     1'b1, 1'b0, 12'd31};
    vecs[7]  = '{"brnc_taken", 12'd30,   op_br(2'b11, 8'hFE),     1'b0, 1'b0, 12'd29};
    vecs[8]  = '{"pc_wrap",    12'd4095, 19'h00055,               1'b0, 1'b0, 12'd0};
    vecs[9]  = '{"br_wrap",    12'd4094, op_br(2'b00, 8'd5),      1'b1, 1'b0, 12'd4};
    vecs[10] = '{"br_min128",  12'd2,    op_br(2'b00, 8'h80),     1'b1, 1'b0, 12'd3971};
    vecs[11] = '{"op_11111",   12'd100,  19'b1111100000000000000, 1'b1, 1'b1, 12'd101};
    vecs[12] = '{"op_100",     12'd100,  19'b1000000000000000011, 1'b1, 1'b1, 12'd101};

    // Reset state and straight-line fetch.
    for (int i = 0; i < 4; i++) mem[i] = 19'h00100 + 19'(i);
    do_reset();
    check("rst_pc", 32'(bus.pc_addr), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_stack_err", 32'(bus.stack_err), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", 32'(bus.pc_addr), 32'(i));
      check("seq_ir", 32'(bus.ir), 32'(19'h00100 + 19'(i - 1)));
      check("seq_ir_valid", 32'(bus.ir_valid), 32'd1);
    end

    // Single-instruction decode table.
    clear_mem();
    for (int v = 0; v < 13; v++) begin
      mem[0] = op_jmp(vecs[v].pc);
      mem[vecs[v].pc] = vecs[v].word;
      bus.z_flag = vecs[v].z;
      bus.c_flag = vecs[v].c;
      do_reset();
      step();
      check({vecs[v].name, "_reach"}, 32'(bus.pc_addr), 32'(vecs[v].pc));
      step();
      check({vecs[v].name, "_pc"}, 32'(bus.pc_addr), 32'(vecs[v].exp_pc));
      check({vecs[v].name, "_ir"}, 32'(bus.ir), 32'(vecs[v].word));
      mem[vecs[v].pc] = '0;
    end
    bus.z_flag = 1'b0;
    bus.c_flag = 1'b0;

    // Stall at pc 7 for three cycles, then resume.
    clear_mem();
    for (int i = 0; i < 12; i++) mem[i] = 19'h00100 + 19'(i);
    do_reset();
    for (int i = 0; i < 7; i++) step();
    check("pre_stall_pc", 32'(bus.pc_addr), 32'd7);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", 32'(bus.pc_addr), 32'd7);
      check("stall_ir_valid", 32'(bus.ir_valid), 32'd0);
      check("stall_ir", 32'(bus.ir), 32'h00106);
    end
    bus.stall = 1'b0;
    step();
    check("resume_pc", 32'(bus.pc_addr), 32'd8);
    check("resume_ir", 32'(bus.ir), 32'h00107);
    check("resume_ir_valid", 32'(bus.ir_valid), 32'd1);
    bus.stall = 1'b1;
    do_reset();
    check("rst_over_stall_pc", 32'(bus.pc_addr), 32'd0);
    check("rst_over_stall_valid", 32'(bus.ir_valid), 32'd0);
    bus.stall = 1'b0;

    // JSB immediately followed by RET, then two-level nesting.
    clear_mem();
    mem[0]  = op_jmp(12'd40);
    mem[40] = op_jsb(12'd45);
    mem[45] = op_ret();
    mem[41] = op_jmp(12'd50);
    mem[50] = op_jsb(12'd60);
    mem[60] = op_jsb(12'd70);
    mem[70] = op_ret();
    mem[61] = op_ret();
    do_reset();
    step();
    check("jsb_at40", 32'(bus.pc_addr), 32'd40);
    step();
    check("jsb_to45", 32'(bus.pc_addr), 32'd45);
    step();
    check("ret_to41", 32'(bus.pc_addr), 32'd41);
    step();
    step();
    check("nest_60", 32'(bus.pc_addr), 32'd60);
    step();
    check("nest_70", 32'(bus.pc_addr), 32'd70);
    step();
    check("nest_ret61", 32'(bus.pc_addr), 32'd61);
    step();
    check("nest_ret51", 32'(bus.pc_addr), 32'd51);

    // Nine nested calls into an eight-deep stack, then nine returns.
    clear_mem();
    mem[0] = op_jmp(12'd200);
    for (int i = 0; i < 9; i++) begin
      mem[200 + 10 * i] = op_jsb(12'(200 + 10 * (i + 1)));
      mem[201 + 10 * i] = op_ret();
    end
    mem[290] = op_ret();
`ifdef STACK_GUARD_EN
    ret_seq = '{12'd271, 12'd261, 12'd251, 12'd241, 12'd231, 12'd221, 12'd211, 12'd201, 12'd202};
`else
    ret_seq = '{12'd281, 12'd271, 12'd261, 12'd251, 12'd241, 12'd231, 12'd221, 12'd211, 12'd281};
`endif
    do_reset();
    step();
    for (int i = 0; i < 8; i++) step();
    check("jsb8_err", 32'(bus.stack_err), 32'd0);
    step();
    check("jsb9_pc", 32'(bus.pc_addr), 32'd290);
`ifdef STACK_GUARD_EN
    check("jsb9_err", 32'(bus.stack_err), 32'd1);
`else
    check("jsb9_err", 32'(bus.stack_err), 32'd0);
`endif
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("ret%0d_pc", i + 1), 32'(bus.pc_addr), 32'(ret_seq[i]));
    end

    // Reset mid-subroutine discards the stack: RET from a fresh reset.
    mem[0] = op_ret();
    do_reset();
    check("rst_clears_err", 32'(bus.stack_err), 32'd0);
    step();
`ifdef STACK_GUARD_EN
    check("empty_ret_pc", 32'(bus.pc_addr), 32'd1);
    check("empty_ret_err", 32'(bus.stack_err), 32'd1);
    do_reset();
    check("err_cleared", 32'(bus.stack_err), 32'd0);
`else
    check("empty_ret_pc", 32'(bus.pc_addr), 32'd0);
    check("empty_ret_err", 32'(bus.stack_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
